dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 25 ++
 rtl/dmem_ram.sv | 26 ++
 rtl/dmem_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// rtl/dmem_ctrl_pkg.sv - shared encodings and address map for the data-memory controller
package dmem_ctrl_pkg;

  localparam logic [2:0] MASK_B  = 3'b000;
  localparam logic [2:0] MASK_H  = 3'b001;
  localparam logic [2:0] MASK_W  = 3'b010;
  localparam logic [2:0] MASK_BU = 3'b100;
  localparam logic [2:0] MASK_HU = 3'b101;

  localparam logic [31:0] RAM_BASE     = 32'h0000_0000;
  localparam logic [31:0] MMIO_BASE    = 32'h8000_0000;
  localparam logic [31:0] GPIO_OFF     = 32'h0000_0000;
  localparam logic [31:0] CYCLE_LO_OFF = 32'h0000_0004;
  localparam logic [31:0] CYCLE_HI_OFF = 32'h0000_0008;

  localparam logic [31:0] GPIO_ADDR     = MMIO_BASE + GPIO_OFF;
  localparam logic [31:0] CYCLE_LO_ADDR = MMIO_BASE + CYCLE_LO_OFF;
  localparam logic [31:0] CYCLE_HI_ADDR = MMIO_BASE + CYCLE_HI_OFF;

  function automatic logic mask_legal(input logic [2:0] m);
    return (m == MASK_B) || (m == MASK_H) || (m == MASK_W) ||
           (m == MASK_BU) || (m == MASK_HU);
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - word RAM with byte-lane write enables, synchronous write, asynchronous read
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - single-cycle data-memory controller: RAM, GPIO and 64-bit cycle counter
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int GPIO_W      = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        mask_i,
  input  logic              wen_i,
  output logic [31:0]       rdata_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              err_o
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_LIMIT = 33'(DEPTH_WORDS) << 2;

  logic [63:0]       cycle_q;
  logic [GPIO_W-1:0] gpio_q;
  logic [GPIO_W-1:0] gpio_d;
  logic              err_q;

  logic [31:0] ram_off;
  logic        is_ram, is_gpio, is_clo, is_chi;
  logic        aligned, access_ok, store_ok;
  logic [3:0]  be;
  logic [31:0] wd, raw, ram_rdata;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign ram_off = addr_i - RAM_BASE;
  assign is_ram  = {1'b0, ram_off} < RAM_LIMIT;
  assign is_gpio = addr_i[31:2] == GPIO_ADDR[31:2];
  assign is_clo  = addr_i[31:2] == CYCLE_LO_ADDR[31:2];
  assign is_chi  = addr_i[31:2] == CYCLE_HI_ADDR[31:2];

  always_comb begin
    aligned = 1'b1;
    case (mask_i[1:0])
      2'b01:   aligned = ~addr_i[0];
      2'b10:   aligned = addr_i[1:0] == 2'b00;
      default: aligned = 1'b1;
    endcase
  end

  assign access_ok = mask_legal(mask_i) && aligned && (is_ram || is_gpio || is_clo || is_chi);
  // Unsigned masks are load-only; counters are read-only.
  assign store_ok  = wen_i && access_ok && ~mask_i[2] && (is_ram || is_gpio);

  always_comb begin
    be = 4'b1111;
    wd = wdata_i;
    case (mask_i[1:0])
      2'b00: begin
        be = 4'b0001 << addr_i[1:0];
        wd = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be = addr_i[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata_i[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata_i;
      end
    endcase
  end

  for (genvar i = 0; i < GPIO_W; i++) begin : g_gpio_lane
    assign gpio_d[i] = be[i/8] ? wd[i] : gpio_q[i];
  end

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk_i (clk_i),
    .we    (store_ok && is_ram && ~reset_i),
    .be    (be),
    .addr  (ram_off[AW+1:2]),
    .wdata (wd),
    .rdata (ram_rdata)
  );

  always_comb begin
    raw = 32'h0;
    if (is_ram)       raw = ram_rdata;
    else if (is_gpio) raw = 32'(gpio_q);
    else if (is_clo)  raw = cycle_q[31:0];
    else if (is_chi)  raw = cycle_q[63:32];
  end

  assign byte_sel = raw[{addr_i[1:0], 3'b000} +: 8];
  assign half_sel = raw[{addr_i[1], 4'b0000} +: 16];

  always_comb begin
    rdata_o = 32'h0;
    if (access_ok) begin
      case (mask_i[1:0])
        2'b00:   rdata_o = mask_i[2] ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        2'b01:   rdata_o = mask_i[2] ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        default: rdata_o = raw;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cycle_q <= 64'h0;
      gpio_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 64'h1;
      if (store_ok && is_gpio) gpio_q <= gpio_d;
      if (wen_i && !store_ok)  err_q  <= 1'b1;
    end
  end

  assign gpio_o = gpio_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - scoreboard bench for dmem_ctrl
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] addr, wdata;
  logic [2:0]  mask;
  logic        wen;
  logic [31:0] rdata;
  logic [7:0]  gpio;
  logic        err;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic [63:0] tb_cyc;
  logic [63:0] cyc_off = 64'h0;
  logic [7:0]  mb[64];

  dmem_ctrl #(.DEPTH_WORDS(1024), .GPIO_W(8)) dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .addr_i  (addr),
    .wdata_i (wdata),
    .mask_i  (mask),
    .wen_i   (wen),
    .rdata_o (rdata),
    .gpio_o  (gpio),
    .err_o   (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset_i)
    if (reset_i) tb_cyc <= 64'h0;
    else         tb_cyc <= tb_cyc + 64'h1;

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m, input logic w);
    @(negedge clk);
    addr = a; wdata = d; mask = m; wen = w;
    #2;
  endtask

  function automatic logic [31:0] mdl_load(input int off, input logic [2:0] m);
    case (m)
      MASK_B:  return {{24{mb[off][7]}}, mb[off]};
      MASK_BU: return {24'h0, mb[off]};
      MASK_H:  return {{16{mb[off+1][7]}}, mb[off+1], mb[off]};
      MASK_HU: return {16'h0, mb[off+1], mb[off]};
      default: return {mb[off+3], mb[off+2], mb[off+1], mb[off]};
    endcase
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; addr = 0; wdata = 0; mask = MASK_W; wen = 0;
    repeat (3) @(negedge clk);
    drive(GPIO_ADDR, 32'hFF, MASK_W, 1'b1);
    drive(CYCLE_LO_ADDR, 32'h0, MASK_W, 1'b0);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_cycle_lo got=%h exp=0", rdata); end
    total++; if (gpio !== 8'h0) begin bad++; $display("FAIL reset_gpio got=%h exp=0", gpio); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
    drive(CYCLE_HI_ADDR, 32'h0, MASK_W, 1'b0);
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_cycle_hi got=%h exp=0", rdata); end
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_word_byte();
    logic [31:0] la[10] = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12, 32'h10, 32'h10, 32'hFFC, 32'h1000, 32'h1010};
    logic [2:0]  lm[10] = '{MASK_W, MASK_B, MASK_BU, MASK_HU, MASK_H, MASK_B, MASK_HU, MASK_W, MASK_W, MASK_W};
    logic [31:0] le[10] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'h0000DEAD, 32'hFFFFDEAD,
                            32'hFFFFFFEF, 32'h0000BEEF, 32'h12345678, 32'h0, 32'h0};
    drive(32'h10, 32'hDEADBEEF, MASK_W, 1'b1);
    drive(32'hFFC, 32'h12345678, MASK_W, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(la[i], 32'h0, lm[i], 1'b0);
      exp_q.push_back(le[i]);
      e = exp_q.pop_front();
      total++; if (rdata !== e) begin bad++; $display("FAIL word_byte[%0d] got=%h exp=%h", i, rdata, e); end
    end
  endtask

  task automatic test_partial();
    logic [31:0] la[4] = '{32'h20, 32'h20, 32'h20, 32'h22};
    logic [2:0]  lm[4] = '{MASK_W, MASK_H, MASK_W, MASK_HU};
    logic [31:0] le[4] = '{32'h1122AA44, 32'hFFFFAA44, 32'hBEEFAA44, 32'h0000BEEF};
    drive(32'h20, 32'h11223344, MASK_W, 1'b1);
    drive(32'h21, 32'hFFFFFFAA, MASK_B, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) drive(32'h22, 32'h1234BEEF, MASK_H, 1'b1);
      drive(la[i], 32'h0, lm[i], 1'b0);
      exp_q.push_back(le[i]);
      e = exp_q.pop_front();
      total++; if (rdata !== e) begin bad++; $display("FAIL partial[%0d] got=%h exp=%h", i, rdata, e); end
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] la[4] = '{32'h21, 32'h20, 32'h21, 32'h1000};
    logic [2:0]  lm[4] = '{MASK_W, 3'b011, MASK_H, MASK_BU};
    for (int i = 0; i < 4; i++) begin
      drive(la[i], 32'h0, lm[i], 1'b0);
      exp_q.push_back(32'h0);
      e = exp_q.pop_front();
      total++; if (rdata !== e) begin bad++; $display("FAIL illegal_read[%0d] got=%h exp=%h", i, rdata, e); end
    end
    drive(32'h0, 32'h0, MASK_W, 1'b0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL read_no_err got=%b exp=0", err); end
    drive(32'h22, 32'h55, MASK_W, 1'b1);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL err_before_edge got=%b exp=0", err); end
    drive(32'h20, 32'h0, MASK_W, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_after_edge got=%b exp=1", err); end
    total++; if (rdata !== 32'hBEEFAA44) begin bad++; $display("FAIL misaligned_noop got=%h exp=BEEFAA44", rdata); end
    drive(32'h20, 32'h77, MASK_HU, 1'b1);
    drive(32'h1000, 32'h77, MASK_W, 1'b1);
    drive(32'h20, 32'h66, 3'b111, 1'b1);
    repeat (3) drive(32'h20, 32'h0, MASK_W, 1'b0);
    total++; if (rdata !== 32'hBEEFAA44) begin bad++; $display("FAIL illegal_store_noop got=%h exp=BEEFAA44", rdata); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_mmio();
    logic [31:0] first;
    logic [2:0]  lm[4] = '{MASK_B, MASK_BU, MASK_W, MASK_HU};
    logic [31:0] le[4] = '{32'hFFFFFFA5, 32'h000000A5, 32'h000000A5, 32'h000000A5};
    @(negedge clk); reset_i = 1'b1; cyc_off = 64'h0;
    @(negedge clk); reset_i = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL mmio_err_cleared got=%b exp=0", err); end
    drive(GPIO_ADDR, 32'h1A5, MASK_W, 1'b1);
    drive(GPIO_ADDR + 32'h1, 32'h77, MASK_B, 1'b1);
    drive(GPIO_ADDR, 32'h0, MASK_W, 1'b0);
    total++; if (gpio !== 8'hA5) begin bad++; $display("FAIL gpio_store got=%h exp=A5", gpio); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL gpio_store_err got=%b exp=0", err); end
    for (int i = 0; i < 4; i++) begin
      drive(GPIO_ADDR, 32'h0, lm[i], 1'b0);
      exp_q.push_back(le[i]);
      e = exp_q.pop_front();
      total++; if (rdata !== e) begin bad++; $display("FAIL gpio_read[%0d] got=%h exp=%h", i, rdata, e); end
    end
    drive(CYCLE_LO_ADDR, 32'h0, MASK_W, 1'b0);
    e = tb_cyc[31:0];
    total++; if (rdata !== e) begin bad++; $display("FAIL cycle_lo got=%h exp=%h", rdata, e); end
    first = rdata;
    repeat (7) drive(CYCLE_LO_ADDR, 32'h0, MASK_W, 1'b0);
    total++; if (rdata - first !== 32'd7) begin bad++; $display("FAIL cycle_delta got=%0d exp=7", rdata - first); end
    drive(CYCLE_LO_ADDR, 32'h0, MASK_W, 1'b1);
    drive(CYCLE_LO_ADDR, 32'h0, MASK_W, 1'b0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL cycle_store_err got=%b exp=1", err); end
    e = tb_cyc[31:0];
    total++; if (rdata !== e) begin bad++; $display("FAIL cycle_unaffected got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle_q;
    cyc_off = 64'h0000_0000_FFFF_FFFF - tb_cyc;
    addr = CYCLE_LO_ADDR; mask = MASK_W; wen = 1'b0;
    #1;
    total++; if (rdata !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_lo_before got=%h exp=FFFFFFFF", rdata); end
    @(posedge clk); #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL wrap_lo_after got=%h exp=0", rdata); end
    addr = CYCLE_HI_ADDR; #1;
    total++; if (rdata !== 32'h1) begin bad++; $display("FAIL wrap_hi_after got=%h exp=1", rdata); end
    repeat (3) drive(CYCLE_LO_ADDR, 32'h0, MASK_W, 1'b0);
    e = 32'(tb_cyc + cyc_off);
    total++; if (rdata !== e) begin bad++; $display("FAIL wrap_follow got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    addr = GPIO_ADDR; wdata = 32'h3C; mask = MASK_W; wen = 1'b1;
    #1 reset_i = 1'b1; cyc_off = 64'h0;
    #1;
    total++; if (gpio !== 8'h0) begin bad++; $display("FAIL midreset_gpio got=%h exp=0", gpio); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL midreset_err got=%b exp=0", err); end
    addr = CYCLE_LO_ADDR; #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL midreset_cycle got=%h exp=0", rdata); end
    addr = GPIO_ADDR;
    @(posedge clk); @(negedge clk);
    total++; if (gpio !== 8'h0) begin bad++; $display("FAIL midreset_store got=%h exp=0", gpio); end
    wen = 1'b0; reset_i = 1'b0;
    drive(32'h10, 32'h0, MASK_W, 1'b0);
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_kept_10 got=%h exp=DEADBEEF", rdata); end
    drive(32'h20, 32'h0, MASK_W, 1'b0);
    total++; if (rdata !== 32'hBEEFAA44) begin bad++; $display("FAIL ram_kept_20 got=%h exp=BEEFAA44", rdata); end
    total++; if (gpio !== 8'h0) begin bad++; $display("FAIL gpio_after_reset got=%h exp=0", gpio); end
  endtask

  task automatic test_back_to_back();
    drive(32'h30, 32'h01020304, MASK_W, 1'b1);
    drive(32'h30, 32'hCAFEF00D, MASK_W, 1'b1);
    total++; if (rdata !== 32'h01020304) begin bad++; $display("FAIL pre_write_read got=%h exp=01020304", rdata); end
    @(posedge clk); #1;
    total++; if (rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL post_write_read got=%h exp=CAFEF00D", rdata); end
    drive(32'h31, 32'h11, MASK_B, 1'b1);
    drive(32'h32, 32'h22, MASK_B, 1'b1);
    drive(32'h30, 32'h0, MASK_W, 1'b0);
    exp_q.push_back(32'hCA22110D);
    e = exp_q.pop_front();
    total++; if (rdata !== e) begin bad++; $display("FAIL b2b_bytes got=%h exp=%h", rdata, e); end
  endtask

  task automatic test_random();
    logic [2:0] lmask[5] = '{MASK_B, MASK_H, MASK_W, MASK_BU, MASK_HU};
    for (int w = 0; w < 16; w++) drive(32'h200 + 32'(w * 4), 32'h0, MASK_W, 1'b1);
    for (int i = 0; i < 64; i++) mb[i] = 8'h0;
    for (int n = 0; n < 60; n++) begin
      int sz, off;
      logic [31:0] d;
      logic [2:0]  m;
      sz = $urandom_range(0, 2);
      off = $urandom_range(0, 63) & ~((1 << sz) - 1);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        drive(32'h200 + 32'(off), d, 3'(sz), 1'b1);
        for (int k = 0; k < (1 << sz); k++) mb[off + k] = d[8*k +: 8];
      end else begin
        m = lmask[$urandom_range(0, 4)];
        off = $urandom_range(0, 63) & ~((1 << m[1:0]) - 1);
        exp_q.push_back(mdl_load(off, m));
        drive(32'h200 + 32'(off), 32'h0, m, 1'b0);
        e = exp_q.pop_front();
        total++; if (rdata !== e) begin bad++; $display("FAIL random[%0d] off=%0d mask=%b got=%h exp=%h", n, off, m, rdata, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_byte();
    test_partial();
    test_misaligned();
    test_mmio();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    drive(32'h0, 32'h0, MASK_W, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
